// File: rtl/counter_down_ld.sv
// Loadable down-counter with one-shot and periodic (auto-reload) modes.
// Emits a one-cycle terminal-count pulse in DONE; loads saturate at ULIMIT.
module counter_down_ld #(
  parameter int unsigned        WIDTH  = 3,
  parameter logic [WIDTH-1:0]   ULIMIT = 3'b110
) (
  input  logic             clk,
  input  logic             i_sclr,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_auto_reload,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_tc,
  output logic             o_busy
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] load_sat;

  assign load_sat = (i_load_val > ULIMIT) ? ULIMIT : i_load_val;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (i_load) begin
      cnt_d    = load_sat;
      reload_d = load_sat;
      state_d  = (load_sat != '0) ? StRun : StIdle;
    end else begin
      unique case (state_q)
        StIdle: cnt_d = '0;
        StRun: begin
          if (i_en) begin
            if (cnt_q > One) begin
              cnt_d = cnt_q - One;
            end else begin
              cnt_d   = '0;
              tc_d    = 1'b1;
              state_d = StDone;
            end
          end
        end
        StDone: begin
          // A zero reload can never reach DONE, but guard so RUN never sees 0.
          if (i_auto_reload && (reload_q != '0)) begin
            cnt_d   = reload_q;
            state_d = StRun;
          end else begin
            cnt_d   = '0;
            state_d = StIdle;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_sclr) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  assign o_cnt  = cnt_q;
  assign o_tc   = tc_q;
  assign o_busy = (state_q == StRun);

endmodule

// File: tb/tb_counter_down_ld.sv
// Directed table-driven bench for counter_down_ld (WIDTH=3, ULIMIT=3'b110).
module tb_counter_down_ld;

  logic       clk;
  logic       i_sclr, i_en, i_load, i_auto_reload;
  logic [2:0] i_load_val;
  logic [2:0] o_cnt;
  logic       o_tc, o_busy;

  int errors = 0;
  int checks = 0;

  counter_down_ld #(
    .WIDTH (3),
    .ULIMIT(3'b110)
  ) dut (
    .clk          (clk),
    .i_sclr       (i_sclr),
    .i_en         (i_en),
    .i_load       (i_load),
    .i_load_val   (i_load_val),
    .i_auto_reload(i_auto_reload),
    .o_cnt        (o_cnt),
    .o_tc         (o_tc),
    .o_busy       (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       sclr;
    logic       load;
    logic [2:0] val;
    logic       en;
    logic       autor;
    logic [2:0] cnt;
    logic       tc;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic sclr, input logic load, input logic [2:0] val,
                              input logic en, input logic autor, input logic [2:0] cnt,
                              input logic tc, input logic busy);
    vec_t v;
    v.sclr = sclr; v.load = load; v.val = val; v.en = en; v.autor = autor;
    v.cnt = cnt; v.tc = tc; v.busy = busy;
    return v;
  endfunction

  task automatic apply(input logic sclr, input logic load, input logic [2:0] val,
                       input logic en, input logic autor);
    i_sclr = sclr; i_load = load; i_load_val = val; i_en = en; i_auto_reload = autor;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [2:0] cnt, input logic tc,
                       input logic busy);
    checks++;
    if ({o_cnt, o_tc, o_busy} !== {cnt, tc, busy}) begin
      errors++;
      $display("FAIL %s: got cnt=%b tc=%b busy=%b, expected cnt=%b tc=%b busy=%b",
               name, o_cnt, o_tc, o_busy, cnt, tc, busy);
    end
  endtask

  initial begin
    i_sclr = 1'b0; i_en = 1'b0; i_load = 1'b0; i_load_val = 3'b000; i_auto_reload = 1'b0;

    // Reset, then enable with no load stays at zero
    vecs.push_back(mk(1, 0, 3'd0, 0, 0, 3'd0, 0, 0));
    vecs.push_back(mk(0, 0, 3'd0, 1, 0, 3'd0, 0, 0));
    vecs.push_back(mk(0, 0, 3'd0, 1, 0, 3'd0, 0, 0));
    // One-shot from 6
    vecs.push_back(mk(0, 1, 3'd6, 1, 0, 3'd6, 0, 1));
    vecs.push_back(mk(0, 0, 3'd0, 1, 0, 3'd5, 0, 1));
    vecs.push_back(mk(0, 0, 3'd0, 1, 0, 3'd4, 0, 1));
    vecs.push_back(mk(0, 0, 3'd0, 1, 0, 3'd3, 0, 1));
    vecs.push_back(mk(0, 0, 3'd0, 1, 0, 3'd2, 0, 1));
    vecs.push_back(mk(0, 0, 3'd0, 1, 0, 3'd1, 0, 1));
    vecs.push_back(mk(0, 0, 3'd0, 1, 0, 3'd0, 1, 0));
    vecs.push_back(mk(0, 0, 3'd0, 1, 0, 3'd0, 0, 0));
    vecs.push_back(mk(0, 0, 3'd0, 1, 0, 3'd0, 0, 0));
    // Saturation, then zero load mid-run
    vecs.push_back(mk(0, 1, 3'd7, 1, 0, 3'd6, 0, 1));
    vecs.push_back(mk(0, 0, 3'd0, 1, 0, 3'd5, 0, 1));
    vecs.push_back(mk(0, 1, 3'd0, 1, 0, 3'd0, 0, 0));
    vecs.push_back(mk(0, 0, 3'd0, 1, 0, 3'd0, 0, 0));
    // Enable hold
    vecs.push_back(mk(0, 1, 3'd4, 1, 0, 3'd4, 0, 1));
    vecs.push_back(mk(0, 0, 3'd0, 1, 0, 3'd3, 0, 1));
    vecs.push_back(mk(0, 0, 3'd0, 1, 0, 3'd2, 0, 1));
    vecs.push_back(mk(0, 0, 3'd0, 0, 0, 3'd2, 0, 1));
    vecs.push_back(mk(0, 0, 3'd0, 0, 0, 3'd2, 0, 1));
    vecs.push_back(mk(0, 0, 3'd0, 0, 0, 3'd2, 0, 1));
    vecs.push_back(mk(0, 0, 3'd0, 1, 0, 3'd1, 0, 1));
    vecs.push_back(mk(0, 0, 3'd0, 1, 0, 3'd0, 1, 0));
    vecs.push_back(mk(0, 0, 3'd0, 1, 0, 3'd0, 0, 0));
    // sclr beats load
    vecs.push_back(mk(0, 1, 3'd5, 1, 0, 3'd5, 0, 1));
    vecs.push_back(mk(1, 1, 3'd3, 1, 0, 3'd0, 0, 0));
    vecs.push_back(mk(0, 0, 3'd0, 1, 0, 3'd0, 0, 0));
    // Load during DONE
    vecs.push_back(mk(0, 1, 3'd1, 1, 0, 3'd1, 0, 1));
    vecs.push_back(mk(0, 0, 3'd0, 1, 0, 3'd0, 1, 0));
    vecs.push_back(mk(0, 1, 3'd2, 1, 0, 3'd2, 0, 1));
    vecs.push_back(mk(0, 0, 3'd0, 1, 0, 3'd1, 0, 1));
    vecs.push_back(mk(1, 0, 3'd0, 1, 0, 3'd0, 0, 0));
    // DONE lasts one cycle even with i_en low
    vecs.push_back(mk(0, 1, 3'd1, 0, 0, 3'd1, 0, 1));
    vecs.push_back(mk(0, 0, 3'd0, 1, 0, 3'd0, 1, 0));
    vecs.push_back(mk(0, 0, 3'd0, 0, 0, 3'd0, 0, 0));
    // sclr during DONE
    vecs.push_back(mk(0, 1, 3'd1, 1, 0, 3'd1, 0, 1));
    vecs.push_back(mk(0, 0, 3'd0, 1, 0, 3'd0, 1, 0));
    vecs.push_back(mk(1, 0, 3'd0, 1, 1, 3'd0, 0, 0));
    vecs.push_back(mk(0, 0, 3'd0, 1, 1, 3'd0, 0, 0));
    // Auto-reload out of DONE with i_en low, then hold
    vecs.push_back(mk(0, 1, 3'd2, 1, 0, 3'd2, 0, 1));
    vecs.push_back(mk(0, 0, 3'd0, 1, 0, 3'd1, 0, 1));
    vecs.push_back(mk(0, 0, 3'd0, 1, 0, 3'd0, 1, 0));
    vecs.push_back(mk(0, 0, 3'd0, 0, 1, 3'd2, 0, 1));
    vecs.push_back(mk(0, 0, 3'd0, 0, 1, 3'd2, 0, 1));

    foreach (vecs[i]) begin
      apply(vecs[i].sclr, vecs[i].load, vecs[i].val, vecs[i].en, vecs[i].autor);
      check($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].tc, vecs[i].busy);
    end

    // Periodic mode from 3: 3,2,1,0,3,... with tc on every 0
    apply(1, 0, 3'd0, 0, 0);
    check("per_reset", 3'd0, 1'b0, 1'b0);
    apply(0, 1, 3'd3, 1, 1);
    check("per_load", 3'd3, 1'b0, 1'b1);
    for (int k = 0; k < 12; k++) begin
      logic [2:0] exp_cnt;
      exp_cnt = 3'(3 - ((k + 1) % 4));
      apply(0, 0, 3'd0, 1, 1);
      check($sformatf("per%0d", k), exp_cnt, exp_cnt == 3'd0, exp_cnt != 3'd0);
    end

    // Periodic from saturated 7 -> 6, period 7
    apply(0, 1, 3'd7, 1, 1);
    check("per6_load", 3'd6, 1'b0, 1'b1);
    for (int k = 0; k < 14; k++) begin
      logic [2:0] exp_cnt;
      exp_cnt = 3'(6 - ((k + 1) % 7));
      apply(0, 0, 3'd0, 1, 1);
      check($sformatf("per6_%0d", k), exp_cnt, exp_cnt == 3'd0, exp_cnt != 3'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/counter_down_ld.md
COUNTER_DOWN_LD -- requirements
Module: counter_down_ld

Interface
REQ-001 SHALL have parameter WIDTH, default 3, meaning bit width of the count and load value.
REQ-002 SHALL have parameter ULIMIT, default 3'b110, meaning maximum loadable count value.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port i_sclr  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port i_en  input  1  count enable; decrement permitted only when high.
REQ-006 SHALL have port i_load  input  1  load strobe, sampled on rising clk.
REQ-007 SHALL have port i_load_val  input  WIDTH  value captured on i_load.
REQ-008 SHALL have port i_auto_reload  input  1  periodic mode select, sampled in DONE.
REQ-009 SHALL have port o_cnt  output  WIDTH  current count, registered.
REQ-010 SHALL have port o_tc  output  1  terminal-count pulse, registered.
REQ-011 SHALL have port o_busy  output  1  high while in RUN, registered/state-decoded.

Function
REQ-012 SHALL implement states IDLE, RUN, DONE.
REQ-013 SHALL hold a reload register of WIDTH bits, written only on an accepted load.
REQ-014 SHALL apply priority per edge: i_sclr > i_load > state behaviour.
REQ-015 SHALL, on i_load in any state with i_load_val > ULIMIT, saturate: loaded value = ULIMIT.
REQ-016 SHALL, on i_load with nonzero (saturated) value V: o_cnt <= V, reload <= V, state <= RUN, o_tc <= 0, in the same edge.
REQ-017 SHALL, on i_load with value 0: o_cnt <= 0, reload <= 0, state <= IDLE, o_tc <= 0.
REQ-018 SHALL, in IDLE without load: hold o_cnt at 0, o_tc = 0, o_busy = 0.
REQ-019 SHALL, in RUN with i_en = 0: hold o_cnt and state; o_tc = 0.
REQ-020 SHALL, in RUN with i_en = 1 and o_cnt > 1: o_cnt <= o_cnt - 1, stay RUN.
REQ-021 SHALL, in RUN with i_en = 1 and o_cnt == 1: o_cnt <= 0, o_tc <= 1, state <= DONE.
REQ-022 SHALL stay in DONE exactly one cycle regardless of i_en; o_tc high for exactly that cycle.
REQ-023 SHALL, leaving DONE with i_auto_reload = 1: o_cnt <= reload, o_tc <= 0, state <= RUN.
REQ-024 SHALL, leaving DONE with i_auto_reload = 0: o_cnt stays 0, o_tc <= 0, state <= IDLE.
REQ-025 SHALL give periodic mode (i_en held high) a period of V+1 cycles: V, V-1, ..., 1, 0, V, ...
REQ-026 SHALL drive o_busy = 1 only in RUN; 0 in IDLE and DONE.
REQ-027 SHALL never let o_cnt underflow below 0 or exceed ULIMIT.

Reset
REQ-028 SHALL, on i_sclr high at a rising edge: state <= IDLE, o_cnt <= 0, o_tc <= 0, o_busy <= 0, reload <= 0.
REQ-029 SHALL let i_sclr override a simultaneous i_load and abort RUN/DONE mid-operation with no o_tc pulse.
REQ-030 SHALL leave outputs undefined only before the first i_sclr edge.

Verification (WIDTH=3, ULIMIT=3'b110)
REQ-031 Reset: i_sclr=1 one edge -> o_cnt=000, o_tc=0, o_busy=0; i_sclr=0, i_en=1, no load -> o_cnt stays 000.
REQ-032 One-shot: load 110, i_auto_reload=0, i_en=1 -> o_cnt 110,101,100,011,010,001,000 (o_tc=1 that cycle only), then IDLE, o_cnt=000, o_busy=0.
REQ-033 Periodic: load 011, i_auto_reload=1, i_en=1 -> o_cnt 011,010,001,000,011,010,...; o_tc every 4th cycle.
REQ-034 Saturation/zero: load 111 -> o_cnt=110; load 000 during RUN -> o_cnt=000, IDLE, no o_tc.
REQ-035 Enable hold: load 100, count to 010, i_en=0 three cycles -> o_cnt holds 010, o_busy=1; i_en=1 -> 001, 000 with o_tc=1.
REQ-036 Conflicts: i_sclr and i_load same edge -> reset values; i_load during DONE -> new value loaded, RUN, o_tc=0 next cycle.
